// File: rtl/r200_imem_loader.sv
// Boot-time instruction-memory loader: takes a length-prefixed, checksummed byte frame,
// writes little-endian words into instruction memory and holds the core until a frame completes.
module r200_imem_loader #(
    parameter int unsigned DEPTH = 1024,
    parameter logic [31:0] BASE  = 32'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic [31:0] mem_waddr,
    output logic [31:0] mem_wdata,
    output logic        mem_wr,
    output logic        cpu_hold,
    output logic        done,
    output logic        err
);

    localparam int unsigned WORD_W = 32;
    localparam int unsigned BUF_W  = 24;

    typedef enum logic [2:0] {S_IDLE, S_LEN, S_DATA, S_CSUM, S_DONE, S_ERR} state_t;

    state_t             state_q, state_d;
    logic [1:0]         byte_cnt_q, byte_cnt_d;
    logic [WORD_W-1:0]  word_cnt_q, word_cnt_d;
    logic [WORD_W-1:0]  n_q, n_d;
    logic [BUF_W-1:0]   buf_q, buf_d;
    logic [7:0]         csum_q, csum_d;
    logic               armed_q;
    logic               byte_ready_d, mem_wr_d, cpu_hold_d, done_d, err_d;
    logic [WORD_W-1:0]  mem_waddr_d, mem_wdata_d;
    logic               accept_c, start_ok_c, load_c;
    logic [WORD_W-1:0]  len_c;

    assign accept_c   = byte_valid && byte_ready;
    // A start coincident with reset release is dropped: armed only after the first clock.
    assign start_ok_c = start && armed_q;
    assign len_c      = {byte_in, buf_q};

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state_q;
        byte_cnt_d  = byte_cnt_q;
        word_cnt_d  = word_cnt_q;
        n_d         = n_q;
        buf_d       = buf_q;
        csum_d      = csum_q;
        mem_wr_d    = 1'b0;
        mem_waddr_d = mem_waddr;
        mem_wdata_d = mem_wdata;
        cpu_hold_d  = cpu_hold;
        done_d      = done;
        err_d       = err;
        load_c      = 1'b0;

        case (state_q)
            S_IDLE: if (start_ok_c) load_c = 1'b1;
            S_LEN: begin
                if (accept_c) begin
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    buf_d      = {byte_in, buf_q[BUF_W-1:8]};
                    if (byte_cnt_q == 2'd3) begin
                        n_d = len_c;
                        if (len_c > WORD_W'(DEPTH)) begin
                            state_d = S_ERR;
                            err_d   = 1'b1;
                        end else if (len_c == '0) begin
                            state_d = S_CSUM;
                        end else begin
                            state_d = S_DATA;
                        end
                    end
                end
            end
            S_DATA: begin
                if (accept_c) begin
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    buf_d      = {byte_in, buf_q[BUF_W-1:8]};
                    csum_d     = csum_q ^ byte_in;
                    if (byte_cnt_q == 2'd3) begin
                        mem_wr_d    = 1'b1;
                        mem_wdata_d = {byte_in, buf_q};
                        mem_waddr_d = BASE + (word_cnt_q << 2);
                        word_cnt_d  = word_cnt_q + 32'd1;
                        if (word_cnt_q + 32'd1 == n_q) state_d = S_CSUM;
                    end
                end
            end
            S_CSUM: begin
                if (accept_c) begin
                    if (byte_in == csum_q) begin
                        state_d    = S_DONE;
                        done_d     = 1'b1;
                        cpu_hold_d = 1'b0;
                    end else begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                    end
                end
            end
            S_DONE:  if (start_ok_c) load_c = 1'b1;
            S_ERR:   if (start_ok_c) load_c = 1'b1;
            default: state_d = S_IDLE;
        endcase

        if (load_c) begin
            state_d    = S_LEN;
            byte_cnt_d = '0;
            word_cnt_d = '0;
            csum_d     = '0;
            done_d     = 1'b0;
            err_d      = 1'b0;
            cpu_hold_d = 1'b1;
        end

        byte_ready_d = (state_d == S_LEN) || (state_d == S_DATA) || (state_d == S_CSUM);
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            byte_cnt_q <= '0;
            word_cnt_q <= '0;
            n_q        <= '0;
            buf_q      <= '0;
            csum_q     <= '0;
            armed_q    <= 1'b0;
            byte_ready <= 1'b0;
            mem_wr     <= 1'b0;
            mem_waddr  <= BASE;
            mem_wdata  <= '0;
            cpu_hold   <= 1'b1;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            word_cnt_q <= word_cnt_d;
            n_q        <= n_d;
            buf_q      <= buf_d;
            csum_q     <= csum_d;
            armed_q    <= 1'b1;
            byte_ready <= byte_ready_d;
            mem_wr     <= mem_wr_d;
            mem_waddr  <= mem_waddr_d;
            mem_wdata  <= mem_wdata_d;
            cpu_hold   <= cpu_hold_d;
            done       <= done_d;
            err        <= err_d;
        end
    end

endmodule

// File: tb/tb_r200_imem_loader.sv
// Self-checking bench for r200_imem_loader: frames built from random words are compared
// against a frame-level model (expected write list, checksum outcome, hold/done/err levels).
module tb_r200_imem_loader;

    localparam int unsigned DEPTH = 1024;
    localparam logic [31:0] BASE  = 32'h0;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic [31:0] mem_waddr;
    logic [31:0] mem_wdata;
    logic        mem_wr;
    logic        cpu_hold;
    logic        done;
    logic        err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] frame_words[$];
    logic [63:0] wr_q[$];
    bit          prev_wr = 1'b0;

    r200_imem_loader #(.DEPTH(DEPTH), .BASE(BASE)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .byte_in(byte_in),
        .byte_valid(byte_valid), .byte_ready(byte_ready), .mem_waddr(mem_waddr),
        .mem_wdata(mem_wdata), .mem_wr(mem_wr), .cpu_hold(cpu_hold),
        .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // Write monitor: records every write and flags a strobe lasting more than one cycle.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && mem_wr === 1'b1) begin
            wr_q.push_back({mem_waddr, mem_wdata});
            n_checks++;
            if (prev_wr) begin
                n_fail++;
                $display("FAIL mem_wr_pulse: strobe high on consecutive cycles at addr %h, required single-cycle", mem_waddr);
            end
        end
        prev_wr = (rst_n === 1'b1 && mem_wr === 1'b1);
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            byte_valid = 1'b0;
        end
        @(negedge clk);
        byte_valid = 1'b1;
        byte_in    = b;
        t = 0;
        while (byte_ready !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        n_checks++;
        if (byte_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL byte_ready_wait: byte_ready=%b, required 1 within 20 cycles", byte_ready);
        end
    endtask

    // Drives a full frame; csum_xor != 0 corrupts the checksum byte.
    task automatic run_frame(input logic [31:0] n, input logic [7:0] csum_xor, input int gap,
                             input string tag);
        logic [7:0]  cs;
        logic [31:0] w;
        logic [63:0] exp;
        bit          good;
        wr_q.delete();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if (cpu_hold !== 1'b1 || byte_ready !== 1'b1 || done !== 1'b0 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL %s start: hold=%b ready=%b done=%b err=%b, required 1 1 0 0",
                     tag, cpu_hold, byte_ready, done, err);
        end
        for (int i = 0; i < 4; i++) send_byte(n[i*8 +: 8], gap);
        if (n > DEPTH) begin
            @(negedge clk);
            byte_valid = 1'b0;
            n_checks++;
            if (err !== 1'b1 || done !== 1'b0 || byte_ready !== 1'b0 || cpu_hold !== 1'b1) begin
                n_fail++;
                $display("FAIL %s len_err: err=%b done=%b ready=%b hold=%b, required 1 0 0 1",
                         tag, err, done, byte_ready, cpu_hold);
            end
            repeat (3) @(negedge clk);
            n_checks++;
            if (wr_q.size() != 0) begin
                n_fail++;
                $display("FAIL %s len_err_writes: %0d writes, required 0", tag, wr_q.size());
            end
            return;
        end
        cs = 8'h00;
        for (int i = 0; i < int'(n); i++) begin
            w = frame_words[i];
            for (int j = 0; j < 4; j++) begin
                send_byte(w[j*8 +: 8], gap);
                cs = cs ^ w[j*8 +: 8];
            end
            if (gap > 0) begin
                @(negedge clk);
                byte_valid = 1'b0;
                n_checks++;
                if (mem_wr !== 1'b1 || mem_waddr !== BASE + 32'(4 * i) || mem_wdata !== w) begin
                    n_fail++;
                    $display("FAIL %s write_latency[%0d]: wr=%b addr=%h data=%h, required 1 %h %h",
                             tag, i, mem_wr, mem_waddr, mem_wdata, BASE + 32'(4 * i), w);
                end
            end
        end
        send_byte(cs ^ csum_xor, gap);
        @(negedge clk);
        byte_valid = 1'b0;
        good = (csum_xor == 8'h00);
        n_checks++;
        if (done !== good || err !== !good || cpu_hold !== !good || byte_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL %s outcome: done=%b err=%b hold=%b ready=%b, required %b %b %b 0",
                     tag, done, err, cpu_hold, byte_ready, good, !good, !good);
        end
        n_checks++;
        if (wr_q.size() != int'(n)) begin
            n_fail++;
            $display("FAIL %s write_count: %0d writes, required %0d", tag, wr_q.size(), n);
        end else begin
            for (int i = 0; i < int'(n); i++) begin
                exp = {BASE + 32'(4 * i), frame_words[i]};
                n_checks++;
                if (wr_q[i] !== exp) begin
                    n_fail++;
                    $display("FAIL %s write[%0d]: addr/data %h, required %h", tag, i, wr_q[i], exp);
                end
            end
        end
    endtask

    task automatic fill_random(input int n);
        frame_words.delete();
        for (int i = 0; i < n; i++) frame_words.push_back($urandom);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_checks++;
        if (cpu_hold !== 1'b1 || byte_ready !== 1'b0 || mem_wr !== 1'b0 || done !== 1'b0 ||
            err !== 1'b0 || mem_waddr !== BASE || mem_wdata !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_values: hold=%b ready=%b wr=%b done=%b err=%b addr=%h data=%h, required 1 0 0 0 0 %h 0",
                     cpu_hold, byte_ready, mem_wr, done, err, mem_waddr, mem_wdata, BASE);
        end
        rst_n = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if (byte_ready !== 1'b0 || cpu_hold !== 1'b1) begin
            n_fail++;
            $display("FAIL start_at_reset_release: ready=%b hold=%b, required 0 1", byte_ready, cpu_hold);
        end
    endtask

    task automatic test_basic();
        frame_words.delete();
        frame_words.push_back(32'h2402_0005);
        frame_words.push_back(32'h0000_000C);
        run_frame(32'd2, 8'h00, 0, "basic");
    endtask

    task automatic test_zero_len();
        frame_words.delete();
        run_frame(32'd0, 8'h00, 0, "zero_ok");
        run_frame(32'd0, 8'h01, 0, "zero_bad");
    endtask

    task automatic test_len_error();
        run_frame(32'(DEPTH + 1), 8'h00, 0, "len_over");
    endtask

    task automatic test_stall();
        fill_random(1);
        run_frame(32'd1, 8'h00, 5, "stall");
    endtask

    task automatic test_reset_midload();
        logic [31:0] w;
        wr_q.delete();
        fill_random(2);
        w = frame_words[0];
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        send_byte(8'd2, 0);
        for (int i = 0; i < 3; i++) send_byte(8'd0, 0);
        send_byte(w[7:0], 0);
        send_byte(w[15:8], 0);
        @(negedge clk);
        byte_valid = 1'b0;
        rst_n      = 1'b0;
        #1;
        n_checks++;
        if (mem_wr !== 1'b0 || cpu_hold !== 1'b1 || byte_ready !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL midload_reset: wr=%b hold=%b ready=%b done=%b, required 0 1 0 0",
                     mem_wr, cpu_hold, byte_ready, done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        n_checks++;
        if (wr_q.size() != 0 || byte_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL midload_idle: writes=%0d ready=%b, required 0 0", wr_q.size(), byte_ready);
        end
        run_frame(32'd2, 8'h00, 0, "restart");
    endtask

    task automatic test_back_to_back();
        fill_random(3);
        run_frame(32'd3, 8'($urandom_range(1, 255)), 0, "reload_bad");
    endtask

    task automatic test_random();
        int n;
        for (int k = 0; k < 8; k++) begin
            n = int'($urandom_range(1, 8));
            fill_random(n);
            run_frame(32'(n), ($urandom_range(0, 2) == 0) ? 8'($urandom_range(1, 255)) : 8'h00,
                      int'($urandom_range(0, 2)), $sformatf("random%0d", k));
        end
    endtask

    task automatic test_depth();
        fill_random(int'(DEPTH));
        run_frame(32'(DEPTH), 8'h00, 0, "full_depth");
    endtask

    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        byte_in    = 8'h00;
        byte_valid = 1'b0;
        test_reset();
        test_basic();
        test_zero_len();
        test_len_error();
        test_stall();
        test_reset_midload();
        test_back_to_back();
        test_random();
        test_depth();
        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
